// File: rtl/vga_pkg.sv
// Shared VGA/zoom-path types and defaults: image size, bus widths and the
// sideband bundle that travels alongside each pixel.
package vga_pkg;
    localparam int IMG_W_DEF = 320;
    localparam int IMG_H_DEF = 240;
    localparam int ADDR_W    = 17;
    localparam int PIX_W     = 8;

    typedef struct packed {
        logic hs;
        logic vs;
        logic video_on;
        logic valid;
        logic in_img;
    } sideband_t;

    // Syncs inactive, no video, nothing valid.
    localparam sideband_t SB_RST = '{hs: 1'b1, vs: 1'b1, video_on: 1'b0, valid: 1'b0, in_img: 1'b0};
endpackage

// File: rtl/pixel_fetch_if.sv
// Zoom-result / memory / DAC bundle for pixel_fetch. The slave modport is the
// fetch stage itself; master is whatever drives coordinates and serves reads.
interface pixel_fetch_if;
    import vga_pkg::*;

    logic [9:0]        img_x;
    logic [9:0]        img_y;
    logic [ADDR_W-1:0] address;
    logic              zoom_done;
    logic              hsync_in;
    logic              vsync_in;
    logic              video_on_in;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_data;
    logic [PIX_W-1:0]  vga_r;
    logic [PIX_W-1:0]  vga_g;
    logic [PIX_W-1:0]  vga_b;
    logic              vga_hs;
    logic              vga_vs;
    logic              vga_blank_n;
`ifdef PIXEL_FETCH_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    modport slave (
        input  img_x, img_y, address, zoom_done, hsync_in, vsync_in, video_on_in, mem_data,
        output mem_rd_en, mem_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n
`ifdef PIXEL_FETCH_UNDERRUN_CNT_EN
        , output underrun_cnt
`endif
    );

    modport master (
        output img_x, img_y, address, zoom_done, hsync_in, vsync_in, video_on_in, mem_data,
        input  mem_rd_en, mem_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n
`ifdef PIXEL_FETCH_UNDERRUN_CNT_EN
        , input underrun_cnt
`endif
    );
endinterface

// File: rtl/sideband_delay.sv
// Fixed-depth shift register for the per-pixel sideband bundle; reset loads
// every stage with the supplied idle value so a flushed pipe shows no video.
module sideband_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_in,
    input  logic      reset,
    input  sideband_t i_rst_val,
    input  sideband_t i_sb,
    output sideband_t o_sb
);
    sideband_t [DEPTH-1:0] r_pipe;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= i_rst_val;
        end else begin
            r_pipe[0] <= i_sb;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_sb = r_pipe[DEPTH-1];
endmodule

// File: rtl/pixel_fetch.sv
// Issues frame-memory reads for zoomed coordinates and drives aligned gray
// pixels + syncs to the DAC. PIXEL_FETCH_UNDERRUN_CNT_EN adds underrun_cnt.
module pixel_fetch
    import vga_pkg::*;
#(
    parameter int              IMG_W        = IMG_W_DEF,
    parameter int              IMG_H        = IMG_H_DEF,
    parameter int              MEM_LAT      = 2,
    parameter logic [PIX_W-1:0] BORDER_COLOR = 8'h00
) (
    input  logic         clk_in,
    input  logic         reset,
    pixel_fetch_if.slave bus
);
    localparam logic [31:0] X_LIM   = 32'(IMG_W);
    localparam logic [31:0] Y_LIM   = 32'(IMG_H);
    localparam logic [31:0] PIX_LIM = 32'(IMG_W * IMG_H);

    logic             w_in_img;
    logic             w_rd;
    logic             w_frame_start;
    sideband_t        w_sb_out;
    sideband_t        r_sb0;
    logic             r_rd_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [PIX_W-1:0] r_pix;
    logic [PIX_W-1:0] r_last_px;
    logic             r_hs;
    logic             r_vs;
    logic             r_blank_n;

    assign w_in_img = (32'(bus.img_x) < X_LIM) && (32'(bus.img_y) < Y_LIM)
                   && (32'(bus.address) < PIX_LIM);
    assign w_rd     = bus.video_on_in && bus.zoom_done && w_in_img;

    // Stage 0: read strobe and sideband capture share one register edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sb0      <= SB_RST;
            r_rd_en    <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_sb0   <= '{hs: bus.hsync_in, vs: bus.vsync_in, video_on: bus.video_on_in,
                         valid: bus.zoom_done, in_img: w_in_img};
            r_rd_en <= w_rd;
            if (w_rd) r_mem_addr <= bus.address;
        end
    end

    sideband_delay #(.DEPTH(MEM_LAT)) u_sb_delay (
        .clk_in    (clk_in),
        .reset     (reset),
        .i_rst_val (SB_RST),
        .i_sb      (r_sb0),
        .o_sb      (w_sb_out)
    );

    // Frame start is seen on the aligned vsync so it lines up with the pixels.
    assign w_frame_start = r_vs && !w_sb_out.vs;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_pix     <= '0;
            r_last_px <= '0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
        end else begin
            r_hs      <= w_sb_out.hs;
            r_vs      <= w_sb_out.vs;
            r_blank_n <= w_sb_out.video_on;
            if (!w_sb_out.video_on)    r_pix <= '0;
            else if (!w_sb_out.valid)  r_pix <= r_last_px;
            else if (!w_sb_out.in_img) r_pix <= BORDER_COLOR;
            else begin
                r_pix     <= bus.mem_data;
                r_last_px <= bus.mem_data;
            end
            if (w_frame_start) r_last_px <= '0;
        end
    end

`ifdef PIXEL_FETCH_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk_in) begin
        if (reset || w_frame_start)
            r_underrun_cnt <= '0;
        else if (w_sb_out.video_on && !w_sb_out.valid && r_underrun_cnt != 16'hFFFF)
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end

    assign bus.underrun_cnt = r_underrun_cnt;
`endif

    assign bus.mem_rd_en   = r_rd_en;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.vga_r       = r_pix;
    assign bus.vga_g       = r_pix;
    assign bus.vga_b       = r_pix;
    assign bus.vga_hs      = r_hs;
    assign bus.vga_vs      = r_vs;
    assign bus.vga_blank_n = r_blank_n;
endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch: directed vector table, frame-start/reset sequences
// and randomized traffic against an input-order reference model.
module tb_pixel_fetch;
    localparam int         LAT  = 2;
    localparam logic [7:0] BC   = 8'h40;
    localparam int         PIPE = LAT + 1;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [16:0] addr;
        logic        zd, hs, vs, vo;
    } vin_t;

    typedef struct {
        logic [7:0]  rgb;
        logic        hs, vs, blank;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        vin_t        v;
        logic        rd;
        logic [7:0]  rgb;
        logic [15:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_fetch_if bus();

    pixel_fetch #(.IMG_W(320), .IMG_H(240), .MEM_LAT(LAT), .BORDER_COLOR(BC)) dut (
        .clk_in (clk),
        .reset  (rst),
        .bus    (bus)
    );

    // Memory returns addr[7:0], LAT cycles after the strobe.
    logic [7:0] mem_q [LAT];
    always @(posedge clk) begin
        mem_q[0] <= bus.mem_addr[7:0];
        for (int i = 1; i < LAT; i++) mem_q[i] <= mem_q[i-1];
    end
    assign bus.mem_data = mem_q[LAT-1];

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    logic [7:0]  m_last;
    logic [15:0] m_cnt;
    logic        m_pvs;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic vin_t vi(int x, int y, int addr, bit zd, bit hs, bit vs, bit vo);
        vin_t v;
        v.x = 10'(x); v.y = 10'(y); v.addr = 17'(addr);
        v.zd = zd; v.hs = hs; v.vs = vs; v.vo = vo;
        return v;
    endfunction

    function automatic bit inside_img(vin_t v);
        return (int'(v.x) < 320) && (int'(v.y) < 240) && (int'(v.addr) < 320 * 240);
    endfunction

    function automatic bit rd_exp(vin_t v);
        return v.vo && v.zd && inside_img(v);
    endfunction

    // Reference: walk pixels in input order, applying the display rules.
    function automatic exp_t model(vin_t v);
        exp_t e;
        bit   fs;
        fs    = m_pvs && !v.vs;
        m_pvs = v.vs;
        e.hs = v.hs; e.vs = v.vs; e.blank = v.vo;
        if (!v.vo)              e.rgb = 8'h00;
        else if (!v.zd)         e.rgb = m_last;
        else if (!inside_img(v)) e.rgb = BC;
        else begin
            e.rgb  = v.addr[7:0];
            m_last = v.addr[7:0];
        end
        if (fs) m_last = 8'h00;
        if (fs) m_cnt = 16'h0;
        else if (v.vo && !v.zd && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        e.cnt = m_cnt;
        return e;
    endfunction

    task automatic drive(vin_t v);
        bus.img_x = v.x; bus.img_y = v.y; bus.address = v.addr;
        bus.zoom_done = v.zd; bus.hsync_in = v.hs; bus.vsync_in = v.vs; bus.video_on_in = v.vo;
    endtask

    task automatic cycle(vin_t v, exp_t e, logic erd);
        exp_t o;
        drive(v);
        expq.push_back(e);
        @(posedge clk); #1;
        chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(erd));
        if (erd) chk("mem_addr", 32'(bus.mem_addr), 32'(v.addr));
        o = expq.pop_front();
        chk("rgb", {8'h0, bus.vga_r, bus.vga_g, bus.vga_b}, {8'h0, o.rgb, o.rgb, o.rgb});
        chk("sync_blank", {29'h0, bus.vga_hs, bus.vga_vs, bus.vga_blank_n}, {29'h0, o.hs, o.vs, o.blank});
`ifdef PIXEL_FETCH_UNDERRUN_CNT_EN
        chk("underrun_cnt", 32'(bus.underrun_cnt), 32'(o.cnt));
`endif
    endtask

    task automatic do_reset(int n);
        exp_t idle;
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
            chk("rst_rd_en", 32'(bus.mem_rd_en), 32'h0);
            chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
            chk("rst_rgb", {8'h0, bus.vga_r, bus.vga_g, bus.vga_b}, 32'h0);
            chk("rst_sync_blank", {29'h0, bus.vga_hs, bus.vga_vs, bus.vga_blank_n}, 32'b110);
`ifdef PIXEL_FETCH_UNDERRUN_CNT_EN
            chk("rst_underrun_cnt", 32'(bus.underrun_cnt), 32'h0);
`endif
        end
        rst = 1'b0;
        expq.delete();
        idle.rgb = 8'h00; idle.hs = 1'b1; idle.vs = 1'b1; idle.blank = 1'b0; idle.cnt = 16'h0;
        for (int i = 0; i < PIPE; i++) expq.push_back(idle);
        m_last = 8'h00; m_cnt = 16'h0; m_pvs = 1'b1;
    endtask

    function automatic vin_t rnd_vin(ref logic vs_state);
        vin_t v;
        if ($urandom_range(0, 19) == 0) vs_state = ~vs_state;
        v.x    = 10'($urandom_range(0, 330));
        v.y    = 10'($urandom_range(0, 250));
        v.addr = ($urandom_range(0, 3) == 0) ? 17'($urandom_range(76790, 76810))
                                             : 17'($urandom_range(0, 76799));
        v.zd   = ($urandom_range(0, 4) != 0);
        v.hs   = ($urandom_range(0, 9) != 0);
        v.vs   = vs_state;
        v.vo   = ($urandom_range(0, 6) != 0);
        return v;
    endfunction

    vec_t tbl[21];

    initial begin
        exp_t e;
        logic vs_state;

        tbl[0]  = '{vi(5, 3, 'h00123, 1, 1, 1, 1),   1, 8'h23, 16'd0};
        tbl[1]  = '{vi(320, 10, 3210, 1, 1, 1, 1),   0, 8'h40, 16'd0};
        tbl[2]  = '{vi(319, 10, 'h00C8F, 1, 1, 1, 1), 1, 8'h8F, 16'd0};
        tbl[3]  = '{vi(0, 239, 76799, 1, 1, 1, 1),   1, 8'hFF, 16'd0};
        tbl[4]  = '{vi(0, 0, 76800, 1, 1, 1, 1),     0, 8'h40, 16'd0};
        tbl[5]  = '{vi(0, 240, 10, 1, 1, 1, 1),      0, 8'h40, 16'd0};
        tbl[6]  = '{vi(1, 1, 'h55, 1, 1, 1, 0),      0, 8'h00, 16'd0};
        tbl[7]  = '{vi(2, 2, 'h80, 1, 1, 1, 1),      1, 8'h80, 16'd0};
        for (int i = 0; i < 5; i++)
            tbl[8+i] = '{vi(2, 2, 'h11, 0, 1, 1, 1), 0, 8'h80, 16'(i + 1)};
        tbl[13] = '{vi(3, 3, 'h7A, 1, 0, 1, 1),      1, 8'h7A, 16'd5};
        // Frame start: underrun on the falling-vsync cycle still shows the
        // held pixel, later underruns show the cleared value.
        tbl[14] = '{vi(4, 4, 'hFF, 1, 1, 1, 1),      1, 8'hFF, 16'd5};
        tbl[15] = '{vi(4, 4, 'h12, 0, 1, 0, 1),      0, 8'hFF, 16'd0};
        tbl[16] = '{vi(4, 4, 'h12, 0, 1, 0, 1),      0, 8'h00, 16'd1};
        tbl[17] = '{vi(4, 4, 'h12, 0, 1, 0, 1),      0, 8'h00, 16'd2};
        tbl[18] = '{vi(5, 5, 'h33, 1, 1, 1, 1),      1, 8'h33, 16'd2};
        tbl[19] = '{vi(5, 5, 'h44, 1, 1, 0, 1),      1, 8'h44, 16'd0};
        tbl[20] = '{vi(5, 5, 'h12, 0, 1, 0, 1),      0, 8'h00, 16'd1};

        // Reset with live, readable inputs on the bus.
        drive(vi(5, 3, 'h00123, 1, 0, 0, 1));
        do_reset(3);

        foreach (tbl[i]) begin
            e = model(tbl[i].v);
            e.rgb = tbl[i].rgb;
            e.cnt = tbl[i].cnt;
            cycle(tbl[i].v, e, tbl[i].rd);
        end

        vs_state = 1'b1;
        for (int i = 0; i < 400; i++) begin
            vin_t v;
            v = rnd_vin(vs_state);
            e = model(v);
            cycle(v, e, rd_exp(v));
        end

        // Mid-line reset with reads in flight, then resume.
        drive(vi(7, 7, 'h0AB, 1, 1, 1, 1));
        do_reset(2);
        vs_state = 1'b1;
        for (int i = 0; i < 40; i++) begin
            vin_t v;
            v = rnd_vin(vs_state);
            e = model(v);
            cycle(v, e, rd_exp(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_fetch.md
# pixel_fetch

Downstream stage of the zoom processor. It takes the processed image coordinates and the 17-bit frame-memory address each cycle, issues the memory read, and delays the VGA sync/blank sideband by the memory latency. It then drives grayscale pixels to the DAC: border colour outside the image area, and a held pixel when the zoom result is not ready.

## Interface
- `IMG_W`, 320: source image width in pixels
- `IMG_H`, 240: source image height in pixels
- `MEM_LAT`, 2: memory read latency in cycles, from `mem_rd_en` to valid `mem_data`; legal range 1..4
- `BORDER_COLOR`, 8'h00: gray level shown outside the image
- `clk_in`  in  1  pixel clock; the only clock
- `reset`  in  1  synchronous, active-high
- `img_x`  in  10  processed X coordinate
- `img_y`  in  10  processed Y coordinate
- `address`  in  17  frame-memory address for (`img_x`, `img_y`)
- `zoom_done`  in  1  coordinate/address inputs are valid this cycle
- `hsync_in`  in  1  raw VGA hsync, active-low
- `vsync_in`  in  1  raw VGA vsync, active-low
- `video_on_in`  in  1  raw active-video flag
- `mem_rd_en`  out  1  memory read strobe
- `mem_addr`  out  17  memory read address
- `mem_data`  in  8  read data, valid `MEM_LAT` cycles after `mem_rd_en`
- `vga_r`, `vga_g`, `vga_b`  out  8 each  pixel colour
- `vga_hs`  out  1  aligned hsync
- `vga_vs`  out  1  aligned vsync
- `vga_blank_n`  out  1  aligned active-video flag

## Operation
- Stage 0 registers all inputs.
- Bounds check uses unsigned compares: `in_img = (img_x < IMG_W) && (img_y < IMG_H) && (address < IMG_W*IMG_H)`.
- Read is issued when `video_on_in && zoom_done && in_img`:
  - `mem_rd_en`=1 and `mem_addr`=`address`, both registered.
  - Otherwise `mem_rd_en`=0 and `mem_addr` holds its previous value.
- A sideband shift register of depth `MEM_LAT` carries {hs, vs, video_on, valid, in_img}. `valid` is the registered `zoom_done`.
- Output stage, in priority order:
  1. `!video_on`: r/g/b = 0.
  2. `!valid`: r/g/b = `last_px` (underrun).
  3. `!in_img`: r/g/b = `BORDER_COLOR`.
  4. Otherwise r = g = b = `mem_data`, and `last_px` is updated to `mem_data`.
- `last_px` resets to 0. It is cleared to 0 on the first cycle where `vsync_in` is low after being high (frame start).
- The X and Y limits are parameters only; no runtime change.

## Timing
- Latency from input to `vga_*` is `MEM_LAT`+2 cycles, identical for pixel data and all sideband signals. hs, vs and blank never skew relative to the pixel.
- Throughput is one pixel per cycle with no stalls. There is no backpressure: `zoom_done` low never stops the pipeline.
- Reset values:
  - `vga_r`, `vga_g`, `vga_b` = 0
  - `vga_hs` = `vga_vs` = 1 (inactive)
  - `vga_blank_n` = 0
  - `mem_rd_en` = 0, `mem_addr` = 0
  - whole sideband pipe = {1, 1, 0, 0, 0}
- Reset asserted mid-line flushes the pipe on the next edge. Outputs take reset values for `MEM_LAT`+2 cycles after deassertion. Any read already in flight is ignored.
- Simultaneous frame start and a valid pixel in the output stage: the pixel is displayed, then `last_px` is cleared.
- Boundaries:
  - `img_x` = `IMG_W`-1 is inside the image; `img_x` = `IMG_W` is border.
  - `address` = 76799 is legal with the defaults; `address` = 76800 is border.

## Configuration
- `PIXEL_FETCH_UNDERRUN_CNT_EN`: when defined, adds output `underrun_cnt` [15:0].
  - Increments once per output cycle with `video_on && !valid`.
  - Saturates at 16'hFFFF.
  - Resets to 0 on `reset`. Clears to 0 at frame start; a frame-start clear wins over a simultaneous increment.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

## Structure
- Shared package `vga_pkg` holds:
  - `IMG_W_DEF`, `IMG_H_DEF`, `ADDR_W` = 17, `PIX_W` = 8
  - a typedef `sideband_t` for the {hs, vs, video_on, valid, in_img} bundle
- One natural sub-module, `sideband_delay`: a parameterised-depth shift register of `sideband_t` with a reset value input.
- The bounds check, read issue, output mux and frame-start detect stay in `pixel_fetch`.

## Test plan
- Reset for 3 cycles with inputs active -> `vga_hs` = `vga_vs` = 1, `vga_blank_n` = 0, rgb = 0, `mem_rd_en` = 0 throughout. First aligned pixel appears `MEM_LAT`+2 cycles after deassertion.
- `MEM_LAT` = 2, memory model returns data = addr[7:0]; input address 0x00123 with `zoom_done` = 1 and `video_on_in` = 1 -> `mem_rd_en` pulses next cycle; rgb = 8'h23 exactly 4 cycles after input, with hs/vs delayed by the same 4 cycles.
- `img_x` = 320, `img_y` = 10, `BORDER_COLOR` = 8'h40 -> no `mem_rd_en`; rgb = 8'h40. `img_x` = 319 -> read issued.
- Pixel 8'h80 followed by 5 cycles of `zoom_done` = 0 while video is on -> rgb holds 8'h80 for 5 cycles; `underrun_cnt` = 5 with the macro defined.
- `video_on_in` = 0 with a valid in-range address -> no read issued, rgb = 0, `vga_blank_n` = 0.
- `vsync_in` falling edge after `last_px` = 8'hFF, followed by an underrun -> rgb = 0; `underrun_cnt` cleared then counts from 1.
